// File: rtl/alu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_if
//   Producer-side and consumer-side handshake bundle for alu_result_buffer.
//   master : drives results in and takes them out (producer + consumer side)
//   slave  : the buffer itself
//   Optional feature macro: ALU_RESULT_ZERO_FLAG_EN (adds out_zero).
// ---------------------------------------------------------------------------
interface alu_result_buffer_if #(
  parameter int data_width = 16
);
  // producer -> buffer
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_func;
  logic [data_width-1:0] in_C;
  logic                  in_overflow;
  // buffer -> consumer
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_func;
  logic [data_width-1:0] out_C;
  logic                  out_overflow;
`ifdef ALU_RESULT_ZERO_FLAG_EN
  logic                  out_zero;

  modport master (
    output in_valid, in_func, in_C, in_overflow, out_ready,
    input  in_ready, out_valid, out_func, out_C, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_func, in_C, in_overflow, out_ready,
    output in_ready, out_valid, out_func, out_C, out_overflow, out_zero
  );
`else
  modport master (
    output in_valid, in_func, in_C, in_overflow, out_ready,
    input  in_ready, out_valid, out_func, out_C, out_overflow
  );

  modport slave (
    input  in_valid, in_func, in_C, in_overflow, out_ready,
    output in_ready, out_valid, out_func, out_C, out_overflow
  );
`endif
endinterface : alu_result_buffer_if

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//   Result stage behind the ALU function units. Each accepted
//   {FuncCode, C, OverflowFlag} result lands in a DEPTH-entry
//   first-word-fall-through FIFO; the consumer drains it over valid/ready.
//   A saturating counter tracks how many accepted results carried overflow.
//
//   Optional feature macro: ALU_RESULT_ZERO_FLAG_EN
//     defined   -> a per-entry zero bit (C == 0) is captured at push and
//                  presented on out_zero for the head entry.
//     undefined -> no zero bit storage and no out_zero port.
// ---------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int data_width = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  alu_result_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_WIDTH-1:0]       ovf_count,
  input  logic                       clear_stats
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]     OCC_ZERO = OCC_W'(0);
  localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] OVF_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] OVF_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] OVF_MAX  = {CNT_WIDTH{1'b1}};

  // One stored result. FuncCode is kept verbatim, never decoded here.
  typedef struct packed {
    logic [3:0]            func;
    logic [data_width-1:0] c;
    logic                  ovf;
`ifdef ALU_RESULT_ZERO_FLAG_EN
    logic                  zero;
`endif
  } entry_t;

  localparam entry_t ENTRY_ZERO = entry_t'(0);

  // Builds the entry to store from the producer-side fields.
  function automatic entry_t build_entry(
    input logic [3:0]            func,
    input logic [data_width-1:0] c,
    input logic                  ovf
  );
    entry_t e;
    e      = ENTRY_ZERO;
    e.func = func;
    e.c    = c;
    e.ovf  = ovf;
`ifdef ALU_RESULT_ZERO_FLAG_EN
    e.zero = (c == {data_width{1'b0}});
`endif
    return e;
  endfunction

  // Saturating increment of the overflow statistics counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == OVF_MAX) begin
      r = v;
    end else begin
      r = v + OVF_ONE;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q,  count_d;
  logic [CNT_WIDTH-1:0] ovf_q,    ovf_d;

  logic   in_ready_s;
  logic   out_valid_s;
  logic   push_s;
  logic   pop_s;
  entry_t wr_entry_s;
  entry_t head_s;

  // Handshake flags depend only on the registered occupancy, so a full
  // buffer refuses a write even in a cycle where the consumer pops.
  assign in_ready_s  = (count_q != OCC_FULL);
  assign out_valid_s = (count_q != OCC_ZERO);
  assign push_s      = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;
  assign wr_entry_s  = build_entry(bus.in_func, bus.in_C, bus.in_overflow);

  // Pointer and occupancy next-state for every push/pop combination.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + OCC_ONE;
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - OCC_ONE;
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
      end
    endcase
  end

  // Overflow statistics: clear wins over a same-cycle increment.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_stats) begin
      ovf_d = OVF_ZERO;
    end else if (push_s && bus.in_overflow) begin
      ovf_d = sat_inc(ovf_q);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control registers: pointers, occupancy and statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= OCC_ZERO;
      ovf_q    <= OVF_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage: written only on an accepted push; cleared on reset so no
  // stale result can ever be presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ENTRY_ZERO;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // First-word-fall-through head; all head fields read as zero when empty.
  always_comb begin
    head_s = ENTRY_ZERO;
    if (out_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = ENTRY_ZERO;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_s;
  assign bus.out_func     = head_s.func;
  assign bus.out_C        = head_s.c;
  assign bus.out_overflow = head_s.ovf;
`ifdef ALU_RESULT_ZERO_FLAG_EN
  assign bus.out_zero     = head_s.zero;
`endif
  assign count            = count_q;
  assign ovf_count        = ovf_q;

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_buffer
//   Self-checking bench. A queue-based reference model tracks FIFO contents
//   and the overflow statistics; a second instance with CNT_WIDTH = 2 shares
//   the same stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic clear_stats;

  logic          drv_valid;
  logic [3:0]    drv_func;
  logic [DW-1:0] drv_c;
  logic          drv_ovf;
  logic          drv_ready;

  logic [2:0] count1, count2;
  logic [7:0] ovf1;
  logic [1:0] ovf2;

  alu_result_buffer_if #(.data_width(DW)) bus1 ();
  alu_result_buffer_if #(.data_width(DW)) bus2 ();

  assign bus1.in_valid    = drv_valid;
  assign bus1.in_func     = drv_func;
  assign bus1.in_C        = drv_c;
  assign bus1.in_overflow = drv_ovf;
  assign bus1.out_ready   = drv_ready;
  assign bus2.in_valid    = drv_valid;
  assign bus2.in_func     = drv_func;
  assign bus2.in_C        = drv_c;
  assign bus2.in_overflow = drv_ovf;
  assign bus2.out_ready   = drv_ready;

  alu_result_buffer #(.data_width(DW), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .count(count1), .ovf_count(ovf1), .clear_stats(clear_stats)
  );

  alu_result_buffer #(.data_width(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .count(count2), .ovf_count(ovf2), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [3:0]    func;
    logic [DW-1:0] c;
    logic          ovf;
  } ent_t;

  ent_t exp_q[$];
  int   m_ovf8;
  int   m_ovf2;
  int   n_checks = 0;
  int   n_pass   = 0;

  // One clock edge: update the model from the inputs held across it.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push = drv_valid && (exp_q.size() < DEPTH);
    pop  = drv_ready && (exp_q.size() > 0);
    e.func = drv_func; e.c = drv_c; e.ovf = drv_ovf;
    @(posedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(e);
    if (clear_stats) begin
      m_ovf8 = 0; m_ovf2 = 0;
    end else if (push && drv_ovf) begin
      m_ovf8 = (m_ovf8 < 255) ? m_ovf8 + 1 : 255;
      m_ovf2 = (m_ovf2 < 3)   ? m_ovf2 + 1 : 3;
    end
    #1;
  endtask

  task automatic idle_inputs();
    drv_valid = 1'b0; drv_ready = 1'b0; drv_func = 4'h0;
    drv_c = 16'h0000; drv_ovf = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear_stats = 1'b0;
    drv_valid = 1'b1; drv_func = 4'hF; drv_c = 16'hFFFF; drv_ovf = 1'b1; drv_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (count1 !== 3'd0) $display("FAIL reset_count: got %0d want 0", count1); else n_pass++;
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus1.out_valid); else n_pass++;
    n_checks++; if (bus1.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus1.in_ready); else n_pass++;
    n_checks++; if (bus1.out_C !== 16'h0000) $display("FAIL reset_out_C: got %h want 0000", bus1.out_C); else n_pass++;
    n_checks++; if (bus1.out_func !== 4'h0) $display("FAIL reset_out_func: got %h want 0", bus1.out_func); else n_pass++;
    n_checks++; if (ovf1 !== 8'd0) $display("FAIL reset_ovf_count: got %0d want 0", ovf1); else n_pass++;
    idle_inputs();
    exp_q.delete(); m_ovf8 = 0; m_ovf2 = 0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    drv_valid = 1'b1; drv_func = 4'b0100; drv_c = 16'h00F0; drv_ovf = 1'b0; drv_ready = 1'b0;
    tick();
    drv_valid = 1'b0;
    n_checks++; if (bus1.out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", bus1.out_valid); else n_pass++;
    n_checks++; if (bus1.out_C !== 16'h00F0) $display("FAIL single_out_C: got %h want 00f0", bus1.out_C); else n_pass++;
    n_checks++; if (bus1.out_func !== 4'b0100) $display("FAIL single_out_func: got %h want 4", bus1.out_func); else n_pass++;
    n_checks++; if (count1 !== 3'd1) $display("FAIL single_count1: got %0d want 1", count1); else n_pass++;
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    n_checks++; if (count1 !== 3'd0) $display("FAIL single_count0: got %0d want 0", count1); else n_pass++;
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL single_empty_valid: got %b want 0", bus1.out_valid); else n_pass++;
    n_checks++; if (bus1.out_C !== 16'h0000) $display("FAIL single_empty_C: got %h want 0000", bus1.out_C); else n_pass++;
  endtask

  task automatic test_fill_full();
    drv_ready = 1'b0; drv_func = 4'h3; drv_ovf = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drv_valid = 1'b1; drv_c = 16'(i);
      tick();
      if (i == 4) begin
        n_checks++; if (bus1.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus1.in_ready); else n_pass++;
      end
    end
    drv_valid = 1'b0;
    n_checks++; if (count1 !== 3'd4) $display("FAIL full_count: got %0d want 4", count1); else n_pass++;
    drv_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (bus1.out_C !== 16'(i)) $display("FAIL drain_order: got %h want %h", bus1.out_C, 16'(i)); else n_pass++;
      tick();
    end
    n_checks++; if (count1 !== 3'd0) $display("FAIL drain_empty: got %0d want 0", count1); else n_pass++;
    // Full buffer with a same-cycle pop must still refuse the write.
    drv_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drv_valid = 1'b1; drv_c = 16'h0010 + 16'(i);
      tick();
    end
    drv_valid = 1'b1; drv_c = 16'h0099; drv_ready = 1'b1;
    tick();
    drv_valid = 1'b0;
    n_checks++; if (count1 !== 3'd3) $display("FAIL full_pop_count: got %0d want 3", count1); else n_pass++;
    for (int i = 2; i <= 4; i++) begin
      n_checks++; if (bus1.out_C !== 16'h0010 + 16'(i)) $display("FAIL full_pop_order: got %h want %h", bus1.out_C, 16'h0010 + 16'(i)); else n_pass++;
      tick();
    end
    drv_ready = 1'b0;
    n_checks++; if (count1 !== 3'd0) $display("FAIL full_pop_empty: got %0d want 0", count1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drv_ready = 1'b0; drv_func = 4'h9; drv_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_valid = 1'b1; drv_c = 16'd100 + 16'(i);
      tick();
    end
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv_c = 16'd102 + 16'(i);
      n_checks++; if (bus1.out_C !== 16'd100 + 16'(i)) $display("FAIL wrap_order: got %0d want %0d", bus1.out_C, 100 + i); else n_pass++;
      tick();
      n_checks++; if (count1 !== 3'd2) $display("FAIL wrap_count: got %0d want 2", count1); else n_pass++;
    end
    drv_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus1.out_C !== 16'd110 + 16'(i)) $display("FAIL wrap_tail: got %0d want %0d", bus1.out_C, 110 + i); else n_pass++;
      tick();
    end
    drv_ready = 1'b0;
  endtask

  task automatic test_stats();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_checks++; if (ovf1 !== 8'd0) $display("FAIL stats_clear: got %0d want 0", ovf1); else n_pass++;
    drv_ready = 1'b1; drv_valid = 1'b1; drv_ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_c = 16'h0A00 + 16'(i);
      tick();
    end
    drv_ovf = 1'b0;
    tick();
    n_checks++; if (ovf1 !== 8'd3) $display("FAIL stats_three: got %0d want 3", ovf1); else n_pass++;
    drv_ovf = 1'b1; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_checks++; if (ovf1 !== 8'd0) $display("FAIL stats_clear_prio: got %0d want 0", ovf1); else n_pass++;
    n_checks++; if (count1 !== 3'd1) $display("FAIL stats_clear_fifo: got %0d want 1", count1); else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (ovf1 !== 8'd5) $display("FAIL stats_five: got %0d want 5", ovf1); else n_pass++;
    n_checks++; if (ovf2 !== 2'd3) $display("FAIL stats_saturate: got %0d want 3", ovf2); else n_pass++;
    // Overflow result offered while full is not accepted and not counted.
    drv_valid = 1'b0; tick();
    drv_ready = 1'b0; drv_valid = 1'b1; drv_ovf = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    drv_ovf = 1'b1;
    tick();
    n_checks++; if (ovf1 !== 8'd5) $display("FAIL stats_full_ignored: got %0d want 5", ovf1); else n_pass++;
    drv_valid = 1'b0; drv_ovf = 1'b0; drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drv_ready = 1'b0;
  endtask

`ifdef ALU_RESULT_ZERO_FLAG_EN
  task automatic test_zero_flag();
    drv_ready = 1'b0; drv_valid = 1'b1; drv_func = 4'h1; drv_ovf = 1'b0;
    drv_c = 16'h0000; tick();
    drv_c = 16'h8000; tick();
    drv_valid = 1'b0;
    n_checks++; if (bus1.out_zero !== 1'b1) $display("FAIL zero_head: got %b want 1", bus1.out_zero); else n_pass++;
    drv_ready = 1'b1; tick();
    n_checks++; if (bus1.out_zero !== 1'b0) $display("FAIL zero_next: got %b want 0", bus1.out_zero); else n_pass++;
    tick();
    drv_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_midstream();
    drv_ready = 1'b0; drv_valid = 1'b1; drv_ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_c = 16'h0C00 + 16'(i); tick();
    end
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (count1 !== 3'd0) $display("FAIL midreset_count: got %0d want 0", count1); else n_pass++;
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", bus1.out_valid); else n_pass++;
    n_checks++; if (ovf1 !== 8'd0) $display("FAIL midreset_ovf: got %0d want 0", ovf1); else n_pass++;
    exp_q.delete(); m_ovf8 = 0; m_ovf2 = 0;
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    ent_t h;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drv_valid   = ($urandom_range(0, 3) != 0);
      drv_ready   = ($urandom_range(0, 2) != 0);
      drv_func    = 4'($urandom());
      drv_c       = 16'($urandom());
      drv_ovf     = ($urandom_range(0, 1) == 1);
      clear_stats = ($urandom_range(0, 31) == 0);
      tick();
      h.func = 4'h0; h.c = 16'h0000; h.ovf = 1'b0;
      if (exp_q.size() > 0) h = exp_q[0];
      n_checks++; if (count1 !== 3'(exp_q.size())) $display("FAIL rnd_count: got %0d want %0d", count1, exp_q.size()); else n_pass++;
      n_checks++; if (bus1.in_ready !== (exp_q.size() != DEPTH)) $display("FAIL rnd_in_ready: got %b want %b", bus1.in_ready, exp_q.size() != DEPTH); else n_pass++;
      n_checks++; if (bus1.out_valid !== (exp_q.size() != 0)) $display("FAIL rnd_out_valid: got %b want %b", bus1.out_valid, exp_q.size() != 0); else n_pass++;
      n_checks++; if (bus1.out_C !== h.c) $display("FAIL rnd_out_C: got %h want %h", bus1.out_C, h.c); else n_pass++;
      n_checks++; if (bus1.out_func !== h.func) $display("FAIL rnd_out_func: got %h want %h", bus1.out_func, h.func); else n_pass++;
      n_checks++; if (bus1.out_overflow !== h.ovf) $display("FAIL rnd_out_ovf: got %b want %b", bus1.out_overflow, h.ovf); else n_pass++;
      n_checks++; if (ovf1 !== 8'(m_ovf8)) $display("FAIL rnd_ovf_count: got %0d want %0d", ovf1, m_ovf8); else n_pass++;
      n_checks++; if (ovf2 !== 2'(m_ovf2)) $display("FAIL rnd_ovf_sat: got %0d want %0d", ovf2, m_ovf2); else n_pass++;
`ifdef ALU_RESULT_ZERO_FLAG_EN
      n_checks++; if (bus1.out_zero !== ((exp_q.size() != 0) && (h.c == 16'h0000))) $display("FAIL rnd_out_zero: got %b", bus1.out_zero); else n_pass++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    m_ovf8 = 0; m_ovf2 = 0;
    test_reset();
    test_single_pass();
    test_fill_full();
    test_back_to_back();
    test_stats();
`ifdef ALU_RESULT_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_result_buffer
